// File: rtl/val2_pkg.sv
// Shared types and helpers for the Val2 shifter-operand pipeline.
package val2_pkg;

  // Widest datapath the block supports; decoded operands are carried at this
  // width and each instance uses only its low WIDTH bits.
  localparam int MAX_W = 64;

  typedef enum logic [2:0] {
    SK_LSL  = 3'd0,
    SK_LSR  = 3'd1,
    SK_ASR  = 3'd2,
    SK_ROR  = 3'd3,
    SK_RRX  = 3'd4,
    SK_NONE = 3'd5
  } shift_kind_t;

  // One decoded beat: what to do, by how much, to which value, with which C.
  // SK_NONE passes rm/cin straight through (immediates and memory offsets).
  typedef struct packed {
    shift_kind_t        kind;
    logic [8:0]         amt;
    logic [MAX_W-1:0]   rm;
    logic               cin;
  } dec_beat_t;

  // 8-bit immediate rotated right by 2*rot4 inside a width-bit word.
  // Bits above width come back as zero.
  function automatic logic [MAX_W-1:0] rotr_imm(input logic [7:0] imm8,
                                                input logic [3:0] rot4,
                                                input int         width);
    logic [MAX_W-1:0] val;
    logic [MAX_W-1:0] mask;
    int               sh;
    val  = {{(MAX_W-8){1'b0}}, imm8};
    mask = '1;
    mask = mask >> (MAX_W - width);
    sh   = 2 * int'(rot4);
    return ((val >> sh) | (val << (width - sh))) & mask;
  endfunction

endpackage

// File: rtl/val2_shift_core.sv
// Combinational barrel shifter: decoded beat in, shifter operand and carry out.
module val2_shift_core
  import val2_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  dec_beat_t          i_dec,
  output logic [WIDTH-1:0]   o_val2,
  output logic               o_carry
);

  localparam int               LW    = $clog2(WIDTH);
  localparam logic [8:0]       W9    = 9'(WIDTH);
  localparam logic [WIDTH-1:0] LSB_M = WIDTH'(1);
  localparam logic [WIDTH-1:0] MSB_M = LSB_M << (WIDTH - 1);

  logic [WIDTH-1:0]        w_rm;
  logic signed [WIDTH-1:0] w_rm_s;
  logic                    w_sign;
  logic [8:0]              w_n;
  logic [8:0]              w_rot9;
  logic                    w_lsl_c;
  logic                    w_rsh_c;
  logic                    w_ror_c;
  logic                    w_unused_rm_hi;

  assign w_rm   = i_dec.rm[WIDTH-1:0];
  assign w_rm_s = w_rm;
  assign w_sign = w_rm[WIDTH-1];
  assign w_n    = i_dec.amt;
  // Rotate amount is the shift amount modulo WIDTH (WIDTH is a power of two).
  assign w_rot9 = {{(9-LW){1'b0}}, w_n[LW-1:0]};
  // Last bit shifted out, valid for 0 < n < WIDTH (and 0 < rot for ROR).
  assign w_lsl_c = |((w_rm << (w_n - 9'd1)) & MSB_M);
  assign w_rsh_c = |((w_rm >> (w_n - 9'd1)) & LSB_M);
  assign w_ror_c = |((w_rm >> (w_rot9 - 9'd1)) & LSB_M);
  // Upper bits of the decoded operand exist only for wider instances.
  assign w_unused_rm_hi = ^i_dec.rm;

  // Select result and carry by shift kind and amount range.
  always_comb begin
    o_val2  = w_rm;
    o_carry = i_dec.cin;
    case (i_dec.kind)
      SK_RRX: begin
        o_val2  = {i_dec.cin, w_rm[WIDTH-1:1]};
        o_carry = w_rm[0];
      end
      SK_LSL: begin
        if (w_n != 9'd0) begin
          if (w_n < W9) begin
            o_val2  = w_rm << w_n;
            o_carry = w_lsl_c;
          end else begin
            o_val2  = '0;
            o_carry = (w_n == W9) ? w_rm[0] : 1'b0;
          end
        end
      end
      SK_LSR: begin
        if (w_n != 9'd0) begin
          if (w_n < W9) begin
            o_val2  = w_rm >> w_n;
            o_carry = w_rsh_c;
          end else begin
            o_val2  = '0;
            o_carry = (w_n == W9) ? w_sign : 1'b0;
          end
        end
      end
      SK_ASR: begin
        if (w_n != 9'd0) begin
          if (w_n < W9) begin
            o_val2  = w_rm_s >>> w_n;
            o_carry = w_rsh_c;
          end else begin
            o_val2  = {WIDTH{w_sign}};
            o_carry = w_sign;
          end
        end
      end
      SK_ROR: begin
        if (w_n != 9'd0) begin
          if (w_rot9 == 9'd0) begin
            o_carry = w_sign;
          end else begin
            o_val2  = (w_rm >> w_rot9) | (w_rm << (W9 - w_rot9));
            o_carry = w_ror_c;
          end
        end
      end
      default: begin
      end
    endcase
  end

endmodule

// File: rtl/val2_pipe.sv
// Pipelined Val2 / shifter-carry generator between ID/EXE and the ALU.
//
// Handshake (both sides): a beat moves on a rising edge where valid && ready.
// valid never waits on ready; a stage is ready when it is empty or its
// downstream is ready, so in_ready is combinational from out_ready. flush and
// rst empty every stage at the next edge and win over a simultaneous accept.
module val2_pipe
  import val2_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int PIPE  = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_mem,
  input  logic              in_imm,
  input  logic [11:0]       in_shift_operand,
  input  logic [WIDTH-1:0]  in_rm_val,
  input  logic [7:0]        in_rs_val,
  input  logic              in_carry,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WIDTH-1:0]  out_val2,
  output logic              out_carry,
  input  logic              flush
);

  localparam logic [8:0] W9 = 9'(WIDTH);

  logic [MAX_W-1:0] w_imm_rot;
  dec_beat_t        w_dec;
  logic             r_out_valid;
  logic [WIDTH-1:0] r_out_val2;
  logic             r_out_carry;
  logic             w_out_ready;

  assign w_imm_rot   = rotr_imm(in_shift_operand[7:0], in_shift_operand[11:8], WIDTH);
  assign w_out_ready = !r_out_valid || out_ready;
  assign out_valid   = r_out_valid;
  assign out_val2    = r_out_val2;
  assign out_carry   = r_out_carry;

  // Decode the instruction fields into kind / amount / operand / carry-in.
  always_comb begin
    w_dec                = '0;
    w_dec.cin            = in_carry;
    w_dec.rm[WIDTH-1:0]  = in_rm_val;
    if (in_mem) begin
      w_dec.kind = SK_NONE;
      w_dec.rm   = {{(MAX_W-12){in_shift_operand[11]}}, in_shift_operand};
    end else if (in_imm) begin
      w_dec.kind = SK_NONE;
      w_dec.rm   = w_imm_rot;
      if (in_shift_operand[11:8] != 4'd0) w_dec.cin = w_imm_rot[WIDTH-1];
    end else begin
      w_dec.kind = shift_kind_t'({1'b0, in_shift_operand[6:5]});
      if (in_shift_operand[4]) begin
        w_dec.amt = {1'b0, in_rs_val};
      end else begin
        w_dec.amt = {4'd0, in_shift_operand[11:7]};
        // Immediate amount 0 encodes LSR/ASR #WIDTH and RRX in place of ROR #0.
        if (in_shift_operand[11:7] == 5'd0) begin
          case (in_shift_operand[6:5])
            2'b01, 2'b10: w_dec.amt  = W9;
            2'b11:        w_dec.kind = SK_RRX;
            default:      w_dec.amt  = 9'd0;
          endcase
        end
      end
    end
  end

  if (PIPE == 2) begin : g_pipe2
    logic       r_s1_valid;
    dec_beat_t  r_s1_dec;
    logic [WIDTH-1:0] w_core_val2;
    logic             w_core_carry;

    assign in_ready = !r_s1_valid || w_out_ready;

    val2_shift_core #(.WIDTH(WIDTH)) u_core (
      .i_dec   (r_s1_dec),
      .o_val2  (w_core_val2),
      .o_carry (w_core_carry)
    );

    // Stage 1: hold the decoded beat.
    always_ff @(posedge clk) begin
      if (rst) begin
        r_s1_valid <= 1'b0;
        r_s1_dec   <= '0;
      end else if (flush) begin
        r_s1_valid <= 1'b0;
      end else if (in_ready) begin
        r_s1_valid <= in_valid;
        if (in_valid) r_s1_dec <= w_dec;
      end
    end

    // Stage 2: register the shifted result; holds while the consumer stalls.
    always_ff @(posedge clk) begin
      if (rst) begin
        r_out_valid <= 1'b0;
        r_out_val2  <= '0;
        r_out_carry <= 1'b0;
      end else if (flush) begin
        r_out_valid <= 1'b0;
      end else if (w_out_ready) begin
        r_out_valid <= r_s1_valid;
        if (r_s1_valid) begin
          r_out_val2  <= w_core_val2;
          r_out_carry <= w_core_carry;
        end
      end
    end
  end else begin : g_pipe1
    logic [WIDTH-1:0] w_core_val2;
    logic             w_core_carry;

    assign in_ready = w_out_ready;

    val2_shift_core #(.WIDTH(WIDTH)) u_core (
      .i_dec   (w_dec),
      .o_val2  (w_core_val2),
      .o_carry (w_core_carry)
    );

    // Single stage: register the shifted result; holds while the consumer stalls.
    always_ff @(posedge clk) begin
      if (rst) begin
        r_out_valid <= 1'b0;
        r_out_val2  <= '0;
        r_out_carry <= 1'b0;
      end else if (flush) begin
        r_out_valid <= 1'b0;
      end else if (w_out_ready) begin
        r_out_valid <= in_valid;
        if (in_valid) begin
          r_out_val2  <= w_core_val2;
          r_out_carry <= w_core_carry;
        end
      end
    end
  end

endmodule
